// File: rtl/vip_avst_video_decoder_if.sv
// Avalon-ST Video decoder bundle: the raw sink stream (din_*) and the
// decoded output stream plus frame fields (dec_*).
// master = stream source / downstream consumer side, slave = the decoder.
interface vip_avst_video_decoder_if #(
   parameter int DATA_W = 24
);
   logic              din_ready;
   logic              din_valid;
   logic [DATA_W-1:0] din_data;
   logic              din_sop;
   logic              din_eop;
   logic              dec_ready;
   logic              dec_valid;
   logic [DATA_W-1:0] dec_data;
   logic              dec_is_video;
   logic              dec_end_of_video;
   logic [15:0]       dec_width;
   logic [15:0]       dec_height;
   logic [3:0]        dec_interlaced;
   logic              dec_vip_ctrl_valid;

   modport master (
      input  din_ready,
      output din_valid, din_data, din_sop, din_eop,
      output dec_ready,
      input  dec_valid, dec_data, dec_is_video, dec_end_of_video,
      input  dec_width, dec_height, dec_interlaced, dec_vip_ctrl_valid
   );

   modport slave (
      output din_ready,
      input  din_valid, din_data, din_sop, din_eop,
      input  dec_ready,
      output dec_valid, dec_data, dec_is_video, dec_end_of_video,
      output dec_width, dec_height, dec_interlaced, dec_vip_ctrl_valid
   );
endinterface

// File: rtl/vip_avst_video_decoder.sv
// Receive-side Avalon-ST Video packet decoder. Classifies packets by the
// header type nibble, decodes control packets into width/height/interlace
// and forwards every beat through one registered stage tagged is_video.
// Optional build macro: VIP_DECODER_STRICT_LEN_EN -- when defined, a control
// packet commits only if all nine nibbles were received.
module vip_avst_video_decoder #(
   parameter int BITS_PER_SYMBOL  = 8,
   parameter int SYMBOLS_PER_BEAT = 3
) (
   input logic clk,
   input logic rst,
   vip_avst_video_decoder_if.slave bus
);
   localparam int DATA_W = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_VIDEO = 2'd1;
   localparam logic [1:0] ST_CTRL  = 2'd2;
   localparam logic [1:0] ST_OTHER = 2'd3;

   // Field vector layout: {width[15:0], height[15:0], interlaced[3:0]};
   // nibble n lives at bits [4*(8-n) +: 4].
   localparam logic [35:0] FIELDS_RST = {16'd640, 16'd480, 4'd0};

   logic [1:0]        state;
   logic              in_xfer;
   logic              out_xfer;
   logic              beat_video;
   logic              ctrl_beat;
   logic              len_ok;
   logic              commit;
   logic [3:0]        cnt;
   logic [4:0]        cnt_sum;
   logic [3:0]        cnt_nxt;
   logic [35:0]       fld;
   logic [35:0]       shd;
   logic [35:0]       shd_nxt;
   logic [DATA_W-1:0] data_p1;
   logic              vld_p1;
   logic              is_video_p1;
   logic              eov_p1;
   logic              ctrl_vld;

   assign in_xfer    = bus.din_valid & bus.din_ready;
   assign out_xfer   = vld_p1 & bus.dec_ready;
   assign beat_video = ~bus.din_sop & (state == ST_VIDEO);
   assign ctrl_beat  = in_xfer & ~bus.din_sop & (state == ST_CTRL);

   // Nibble counter advances by one beat's worth of lanes, saturating at 9.
   assign cnt_sum = {1'b0, cnt} + 5'(SYMBOLS_PER_BEAT);
   assign cnt_nxt = (cnt_sum >= 5'd9) ? 4'd9 : cnt_sum[3:0];

`ifdef VIP_DECODER_STRICT_LEN_EN
   assign len_ok = (cnt_nxt == 4'd9);
`else
   assign len_ok = 1'b1;
`endif

   // The eop beat's own nibbles must be part of the commit, so commit uses shd_nxt.
   assign commit = ctrl_beat & bus.din_eop & len_ok;

   // Merge this beat's lane nibbles into the shadow fields; nibbles past 8 are dropped.
   always_comb begin
      shd_nxt = shd;
      for (int s = 0; s < SYMBOLS_PER_BEAT; s++) begin
         for (int k = 0; k < 9; k++) begin
            if (int'(cnt) + s == k)
               shd_nxt[4*(8-k) +: 4] = bus.din_data[s*BITS_PER_SYMBOL +: 4];
         end
      end
   end

   // Packet-type FSM: a SOP header always overrides, an eop returns to idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else if (in_xfer) begin
         if (bus.din_sop) begin
            if (bus.din_eop)                   state <= ST_IDLE;
            else if (bus.din_data[3:0] == 4'h0) state <= ST_VIDEO;
            else if (bus.din_data[3:0] == 4'hF) state <= ST_CTRL;
            else                               state <= ST_OTHER;
         end else if (bus.din_eop) begin
            state <= ST_IDLE;
         end
      end
   end

   // Control decode: shadows track the packet, fields update only on commit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt      <= 4'd0;
         shd      <= FIELDS_RST;
         fld      <= FIELDS_RST;
         ctrl_vld <= 1'b0;
      end else begin
         ctrl_vld <= 1'b0;
         if (in_xfer && bus.din_sop && bus.din_data[3:0] == 4'hF) begin
            shd <= fld;
            cnt <= 4'd0;
         end else if (ctrl_beat) begin
            shd <= shd_nxt;
            cnt <= cnt_nxt;
            if (commit) begin
               fld      <= shd_nxt;
               ctrl_vld <= 1'b1;
            end
         end
      end
   end

   // ---- stage p1: output register, loads on every accepted beat ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1      <= 1'b0;
         data_p1     <= '0;
         is_video_p1 <= 1'b0;
         eov_p1      <= 1'b0;
      end else if (in_xfer) begin
         vld_p1      <= 1'b1;
         data_p1     <= bus.din_data;
         is_video_p1 <= beat_video;
         eov_p1      <= beat_video & bus.din_eop;
      end else if (out_xfer) begin
         vld_p1      <= 1'b0;
      end
   end

   assign bus.din_ready          = ~vld_p1 | bus.dec_ready;
   assign bus.dec_valid          = vld_p1;
   assign bus.dec_data           = data_p1;
   assign bus.dec_is_video       = is_video_p1;
   assign bus.dec_end_of_video   = eov_p1;
   assign bus.dec_width          = fld[35:20];
   assign bus.dec_height         = fld[19:4];
   assign bus.dec_interlaced     = fld[3:0];
   assign bus.dec_vip_ctrl_valid = ctrl_vld;

endmodule

// File: tb/tb_vip_avst_video_decoder.sv
// Directed testbench for vip_avst_video_decoder (BPS=8, SPB=3).
module tb_vip_avst_video_decoder;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;

   vip_avst_video_decoder_if #(.DATA_W(24)) bus ();

   vip_avst_video_decoder #(
      .BITS_PER_SYMBOL  (8),
      .SYMBOLS_PER_BEAT (3)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check_vec(input string tag, input logic [35:0] obs, input logic [35:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic beat(input logic [23:0] d, input logic s, input logic e);
      bus.din_valid = 1'b1;
      bus.din_data  = d;
      bus.din_sop   = s;
      bus.din_eop   = e;
      @(posedge clk); #1;
      bus.din_valid = 1'b0;
      bus.din_sop   = 1'b0;
      bus.din_eop   = 1'b0;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic check_reset_state(input string tag);
      check_vec({tag, "_din_ready"}, bus.din_ready, 1);
      check_vec({tag, "_valid"}, bus.dec_valid, 0);
      check_vec({tag, "_data"}, bus.dec_data, 0);
      check_vec({tag, "_is_video"}, bus.dec_is_video, 0);
      check_vec({tag, "_eov"}, bus.dec_end_of_video, 0);
      check_vec({tag, "_ctrl_valid"}, bus.dec_vip_ctrl_valid, 0);
      check_vec({tag, "_width"}, bus.dec_width, 640);
      check_vec({tag, "_height"}, bus.dec_height, 480);
      check_vec({tag, "_interlaced"}, bus.dec_interlaced, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [23:0] vec [5];
      logic [23:0] got_d [5];
      logic        got_v [5];
      logic        got_e [5];
      logic [23:0] held;
      logic        held_chk;
      logic        m_vld;
      logic        acc_in;
      logic        acc_out;
      logic        exp_rdy;
      logic [15:0] exp_w;
      int          idx;
      int          nout;
      int          cyc;

      bus.din_valid = 1'b0;
      bus.din_data  = '0;
      bus.din_sop   = 1'b0;
      bus.din_eop   = 1'b0;
      bus.dec_ready = 1'b1;

      // Reset values while reset is held.
      repeat (2) @(posedge clk);
      #1;
      check_reset_state("rst_init");
      rst = 1'b0;
      step();

      // Full control packet: 1920x1080 progressive.
      beat(24'h00000F, 1'b1, 1'b0);
      check_vec("ctl_hdr_valid", bus.dec_valid, 1);
      check_vec("ctl_hdr_data", bus.dec_data, 24'h00000F);
      check_vec("ctl_hdr_is_video", bus.dec_is_video, 0);
      beat(24'h080700, 1'b0, 1'b0);
      check_vec("ctl_b1_is_video", bus.dec_is_video, 0);
      check_vec("ctl_b1_no_pulse", bus.dec_vip_ctrl_valid, 0);
      beat(24'h040000, 1'b0, 1'b0);
      check_vec("ctl_b2_width_held", bus.dec_width, 640);
      beat(24'h000803, 1'b0, 1'b1);
      check_vec("ctl_eop_data", bus.dec_data, 24'h000803);
      check_vec("ctl_eop_is_video", bus.dec_is_video, 0);
      check_vec("ctl_eop_eov", bus.dec_end_of_video, 0);
      check_vec("ctl_pulse", bus.dec_vip_ctrl_valid, 1);
      check_vec("ctl_width", bus.dec_width, 1920);
      check_vec("ctl_height", bus.dec_height, 1080);
      check_vec("ctl_interlaced", bus.dec_interlaced, 0);
      step();
      check_vec("ctl_pulse_end", bus.dec_vip_ctrl_valid, 0);
      check_vec("ctl_drained", bus.dec_valid, 0);
      check_vec("ctl_width_kept", bus.dec_width, 1920);

      // Video packet, no backpressure.
      beat(24'h000000, 1'b1, 1'b0);
      check_vec("vid_hdr_is_video", bus.dec_is_video, 0);
      check_vec("vid_hdr_eov", bus.dec_end_of_video, 0);
      beat(24'h111111, 1'b0, 1'b0);
      check_vec("vid_b1_is_video", bus.dec_is_video, 1);
      check_vec("vid_b1_eov", bus.dec_end_of_video, 0);
      beat(24'h222222, 1'b0, 1'b0);
      check_vec("vid_b2_is_video", bus.dec_is_video, 1);
      beat(24'h333333, 1'b0, 1'b0);
      check_vec("vid_b3_eov", bus.dec_end_of_video, 0);
      beat(24'h444444, 1'b0, 1'b1);
      check_vec("vid_b4_data", bus.dec_data, 24'h444444);
      check_vec("vid_b4_is_video", bus.dec_is_video, 1);
      check_vec("vid_b4_eov", bus.dec_end_of_video, 1);
      check_vec("vid_no_pulse", bus.dec_vip_ctrl_valid, 0);
      step();

      // Video packet with dec_ready toggling 1010...
      vec[0] = 24'h000000; vec[1] = 24'hA1A2A3; vec[2] = 24'hB1B2B3;
      vec[3] = 24'hC1C2C3; vec[4] = 24'hD1D2D3;
      idx = 0; nout = 0; cyc = 0; m_vld = 1'b0; held_chk = 1'b0; held = '0;
      while (nout < 5 && cyc < 60) begin
         bus.dec_ready = (cyc % 2 == 0);
         if (idx < 5) begin
            bus.din_valid = 1'b1;
            bus.din_data  = vec[idx];
            bus.din_sop   = (idx == 0);
            bus.din_eop   = (idx == 4);
         end else begin
            bus.din_valid = 1'b0;
            bus.din_sop   = 1'b0;
            bus.din_eop   = 1'b0;
         end
         #1;
         exp_rdy = !m_vld || bus.dec_ready;
         if (held_chk) check_vec("bp_hold_data", bus.dec_data, held);
         check_vec("bp_din_ready", bus.din_ready, exp_rdy);
         check_vec("bp_valid", bus.dec_valid, m_vld);
         acc_in  = bus.din_valid && exp_rdy;
         acc_out = m_vld && bus.dec_ready;
         if (acc_out) begin
            if (nout < 5) begin
               got_d[nout] = bus.dec_data;
               got_v[nout] = bus.dec_is_video;
               got_e[nout] = bus.dec_end_of_video;
            end
            nout++;
         end
         held_chk = m_vld && !bus.dec_ready;
         held     = bus.dec_data;
         if (acc_in) idx++;
         m_vld = acc_in || (m_vld && !acc_out);
         @(posedge clk); #1;
         cyc++;
      end
      check_vec("bp_beat_count", 36'(nout), 5);
      for (int i = 0; i < 5 && i < nout; i++) begin
         check_vec($sformatf("bp_data%0d", i), got_d[i], vec[i]);
         check_vec($sformatf("bp_is_video%0d", i), got_v[i], (i != 0));
         check_vec($sformatf("bp_eov%0d", i), got_e[i], (i == 4));
      end
      bus.din_valid = 1'b0;
      bus.din_sop   = 1'b0;
      bus.din_eop   = 1'b0;
      bus.dec_ready = 1'b1;
      step();

      // Reset mid-packet with an output beat held by backpressure.
      bus.dec_ready = 1'b0;
      beat(24'h000000, 1'b1, 1'b0);
      check_vec("mrst_held_valid", bus.dec_valid, 1);
      bus.din_valid = 1'b1;
      bus.din_data  = 24'h555555;
      #2;
      rst = 1'b1;
      #1;
      check_reset_state("mrst");
      @(posedge clk); #1;
      rst = 1'b0;
      bus.din_valid = 1'b0;
      bus.dec_ready = 1'b1;
      step();
      beat(24'hABCDEF, 1'b0, 1'b0);
      check_vec("stray_is_video", bus.dec_is_video, 0);
      check_vec("stray_data", bus.dec_data, 24'hABCDEF);
      step();

      // Short control packet: header plus one eop beat.
`ifdef VIP_DECODER_STRICT_LEN_EN
      exp_w = 16'd640;
`else
      exp_w = 16'd0;
`endif
      beat(24'h00000F, 1'b1, 1'b0);
      beat(24'h000000, 1'b0, 1'b1);
`ifdef VIP_DECODER_STRICT_LEN_EN
      check_vec("short_pulse", bus.dec_vip_ctrl_valid, 0);
`else
      check_vec("short_pulse", bus.dec_vip_ctrl_valid, 1);
`endif
      check_vec("short_width", bus.dec_width, exp_w);
      check_vec("short_height", bus.dec_height, 480);
      check_vec("short_interlaced", bus.dec_interlaced, 0);
      step();
      check_vec("short_pulse_end", bus.dec_vip_ctrl_valid, 0);

      // Other packet type.
      beat(24'h000003, 1'b1, 1'b0);
      beat(24'h777777, 1'b0, 1'b1);
      check_vec("other_is_video", bus.dec_is_video, 0);
      check_vec("other_eov", bus.dec_end_of_video, 0);
      check_vec("other_no_pulse", bus.dec_vip_ctrl_valid, 0);

      // Control packet aborted by a video header.
      beat(24'h00000F, 1'b1, 1'b0);
      beat(24'h123456, 1'b0, 1'b0);
      beat(24'h000000, 1'b1, 1'b0);
      check_vec("abort_hdr_is_video", bus.dec_is_video, 0);
      check_vec("abort_hdr_pulse", bus.dec_vip_ctrl_valid, 0);
      beat(24'hAAAAAA, 1'b0, 1'b0);
      check_vec("abort_b1_is_video", bus.dec_is_video, 1);
      beat(24'hBBBBBB, 1'b0, 1'b1);
      check_vec("abort_b2_is_video", bus.dec_is_video, 1);
      check_vec("abort_b2_eov", bus.dec_end_of_video, 1);
      check_vec("abort_no_pulse", bus.dec_vip_ctrl_valid, 0);
      check_vec("abort_width", bus.dec_width, exp_w);
      check_vec("abort_height", bus.dec_height, 480);
      step();
      check_vec("abort_pulse_after", bus.dec_vip_ctrl_valid, 0);
      check_vec("final_drained", bus.dec_valid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
